// File: rtl/sad_buf_if.sv
// Serial pixel stream between a pixel source and the SAD buffer controller.
// The source owns valid/data and the controller owns ready.
interface sad_buf_if #(
    parameter int WIDTH = 8
);
    logic             pix_valid;
    logic [WIDTH-1:0] pix_in;
    logic             pix_ready;

    modport master (
        output pix_valid,
        output pix_in,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_in,
        output pix_ready
    );
endinterface

// File: rtl/sad_buf_ctrl.sv
// Loads one reference block and NUM_CAND candidate blocks into serial buffers
// and launches the SAD datapath once per candidate, reusing the reference buffer.
module sad_buf_ctrl #(
    parameter int WIDTH    = 8,
    parameter int BUF_SIZE = 80,
    parameter int CNT_W    = 7,
    parameter int NUM_CAND = 4,
    localparam int CAND_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sad_buf_if.slave          pix,
    input  logic              ref_full,
    input  logic              cand_full,
    output logic              ref_wr_en,
    output logic              cand_wr_en,
    output logic [WIDTH-1:0]  buf_data,
    output logic              ref_clr,
    output logic              cand_clr,
    output logic              sad_start,
    input  logic              sad_done,
    output logic [CAND_W-1:0] cand_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0]  BUF_CNT  = CNT_W'(BUF_SIZE);
    localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR_ALL   = 3'd1,
        LOAD_REF  = 3'd2,
        LOAD_CAND = 3'd3,
        COMPUTE   = 3'd4,
        WAIT_SAD  = 3'd5,
        CLR_CAND  = 3'd6,
        FINISH    = 3'd7
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic             in_load_s;
    logic             cnt_full_s;
    logic             accept_s;

    // Ready/write strobes stay combinational so a pixel lands in the buffer the cycle it is offered.
    assign in_load_s     = (state_r == LOAD_REF) || (state_r == LOAD_CAND);
    assign cnt_full_s    = (pix_cnt_r >= BUF_CNT);
    assign pix.pix_ready = in_load_s && !cnt_full_s;
    assign accept_s      = pix.pix_valid && pix.pix_ready;
    assign ref_wr_en     = accept_s && (state_r == LOAD_REF);
    assign cand_wr_en    = accept_s && (state_r == LOAD_CAND);
    assign buf_data      = pix.pix_in;

    // Job sequencer: state, pixel/candidate counters and the registered control strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            pix_cnt_r <= {CNT_W{1'b0}};
            cand_idx  <= {CAND_W{1'b0}};
            sad_start <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ref_clr   <= 1'b1;
            cand_clr  <= 1'b1;
        end else begin
            sad_start <= 1'b0;
            done      <= 1'b0;
            ref_clr   <= 1'b0;
            cand_clr  <= 1'b0;
            if (accept_s) begin
                pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= CLR_ALL;
                        ref_clr  <= 1'b1;
                        cand_clr <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CLR_ALL: begin
                    pix_cnt_r <= {CNT_W{1'b0}};
                    cand_idx  <= {CAND_W{1'b0}};
                    state_r   <= LOAD_REF;
                end
                LOAD_REF: begin
                    // A buffer that does not report full after exactly BUF_SIZE writes is flagged
                    // but the load keeps waiting for it rather than aborting the job.
                    if (cnt_full_s) begin
                        if (ref_full) begin
                            state_r   <= LOAD_CAND;
                            pix_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (ref_full) begin
                        err <= 1'b1;
                    end
                end
                LOAD_CAND: begin
                    if (cnt_full_s) begin
                        if (cand_full) begin
                            state_r   <= COMPUTE;
                            sad_start <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (cand_full) begin
                        err <= 1'b1;
                    end
                end
                COMPUTE: begin
                    state_r <= WAIT_SAD;
                end
                WAIT_SAD: begin
                    if (sad_done) begin
                        if (cand_idx == LAST_IDX) begin
                            state_r <= FINISH;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= CLR_CAND;
                            cand_clr <= 1'b1;
                        end
                    end
                end
                CLR_CAND: begin
                    pix_cnt_r <= {CNT_W{1'b0}};
                    cand_idx  <= cand_idx + CAND_W'(1);
                    state_r   <= LOAD_CAND;
                end
                FINISH: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
